// File: rtl/mont_red.sv
// Streaming Montgomery reduction for Kyber (q = 3329, R = 2^16): r = a * 2^-16 mod q, valid/ready with a sideband tag.
// Build option MONT_RED_CANON_EN adds a fourth stage that folds the result into [0, q-1].
module mont_red #(
  parameter logic signed [15:0] Q     = 16'sd3329,
  parameter logic signed [15:0] QINV  = -16'sd3327,
  parameter int                 TAG_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [31:0]      in_data,
  input  logic        [TAG_W-1:0] in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [15:0]      out_data,
  output logic        [TAG_W-1:0] out_tag
);

  localparam logic [15:0] QINV_U = QINV;
  localparam logic [31:0] Q_EXT  = {{16{Q[15]}}, Q};

  logic en;

  logic             s1_valid_q, s1_valid_d;
  logic [31:0]      s1_a_q,     s1_a_d;
  logic [15:0]      s1_t_q,     s1_t_d;
  logic [TAG_W-1:0] s1_tag_q,   s1_tag_d;

  logic             s2_valid_q, s2_valid_d;
  logic [31:0]      s2_a_q,     s2_a_d;
  logic [31:0]      s2_p_q,     s2_p_d;
  logic [TAG_W-1:0] s2_tag_q,   s2_tag_d;

  logic             s3_valid_q, s3_valid_d;
  logic [15:0]      s3_r_q,     s3_r_d;
  logic [TAG_W-1:0] s3_tag_q,   s3_tag_d;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_t_d     = s1_t_q;
    s1_tag_d   = s1_tag_q;
    s2_valid_d = s2_valid_q;
    s2_a_d     = s2_a_q;
    s2_p_d     = s2_p_q;
    s2_tag_d   = s2_tag_q;
    s3_valid_d = s3_valid_q;
    s3_r_d     = s3_r_q;
    s3_tag_d   = s3_tag_q;
    if (en) begin
      s1_valid_d = in_valid;
      s2_valid_d = s1_valid_q;
      s3_valid_d = s2_valid_q;
      if (in_valid) begin
        s1_a_d   = in_data;
        // only the low 16 bits of a*QINV matter, so a 16x16 product suffices
        s1_t_d   = 16'(in_data[15:0] * QINV_U);
        s1_tag_d = in_tag;
      end
      if (s1_valid_q) begin
        s2_a_d   = s1_a_q;
        s2_p_d   = {{16{s1_t_q[15]}}, s1_t_q} * Q_EXT;
        s2_tag_d = s1_tag_q;
      end
      if (s2_valid_q) begin
        // low half of a - t*q is zero by construction, so the upper half is the exact quotient
        s3_r_d   = 16'((s2_a_q - s2_p_q) >> 16);
        s3_tag_d = s2_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_t_q     <= '0;
      s1_tag_q   <= '0;
      s2_valid_q <= 1'b0;
      s2_a_q     <= '0;
      s2_p_q     <= '0;
      s2_tag_q   <= '0;
      s3_valid_q <= 1'b0;
      s3_r_q     <= '0;
      s3_tag_q   <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_a_q     <= s1_a_d;
      s1_t_q     <= s1_t_d;
      s1_tag_q   <= s1_tag_d;
      s2_valid_q <= s2_valid_d;
      s2_a_q     <= s2_a_d;
      s2_p_q     <= s2_p_d;
      s2_tag_q   <= s2_tag_d;
      s3_valid_q <= s3_valid_d;
      s3_r_q     <= s3_r_d;
      s3_tag_q   <= s3_tag_d;
    end
  end

`ifdef MONT_RED_CANON_EN
  logic             s4_valid_q, s4_valid_d;
  logic [15:0]      s4_r_q,     s4_r_d;
  logic [TAG_W-1:0] s4_tag_q,   s4_tag_d;

  always_comb begin
    s4_valid_d = s4_valid_q;
    s4_r_d     = s4_r_q;
    s4_tag_d   = s4_tag_q;
    if (en) begin
      s4_valid_d = s3_valid_q;
      if (s3_valid_q) begin
        s4_r_d   = s3_r_q[15] ? 16'(s3_r_q + Q) : s3_r_q;
        s4_tag_d = s3_tag_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s4_valid_q <= 1'b0;
      s4_r_q     <= '0;
      s4_tag_q   <= '0;
    end else begin
      s4_valid_q <= s4_valid_d;
      s4_r_q     <= s4_r_d;
      s4_tag_q   <= s4_tag_d;
    end
  end

  assign en        = ~s4_valid_q | out_ready;
  assign out_valid = s4_valid_q;
  assign out_data  = s4_r_q;
  assign out_tag   = s4_tag_q;
`else
  assign en        = ~s3_valid_q | out_ready;
  assign out_valid = s3_valid_q;
  assign out_data  = s3_r_q;
  assign out_tag   = s3_tag_q;
`endif

  assign in_ready = en;

endmodule

// File: tb/tb_mont_red.sv
// Directed and scoreboarded bench for mont_red; expectations come from hand-computed
// constants and a congruence/range model (r == a*169 mod 3329).
`timescale 1ns/1ps
module tb_mont_red;

`ifdef MONT_RED_CANON_EN
  localparam int LAT   = 4;
  localparam bit CANON = 1'b1;
`else
  localparam int LAT   = 3;
  localparam bit CANON = 1'b0;
`endif
  localparam int QM    = 3329;
  localparam int AHALF = 109084672;  // q * 2^15

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic signed [31:0] in_data = '0;
  logic        [7:0]  in_tag = '0;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic signed [15:0] out_data;
  logic        [7:0]  out_tag;

  int n_checks = 0;
  int n_pass   = 0;
  int          sb_a[$];
  logic [7:0]  sb_tag[$];

  always #5 clk = ~clk;

  mont_red #(.TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_tag(out_tag)
  );

  function automatic int mod_q(longint v);
    longint m;
    m = v % QM;
    if (m < 0) m = m + QM;
    return int'(m);
  endfunction

  function automatic bit result_ok(int a, logic signed [15:0] r);
    int e;
    e = mod_q(longint'(a) * 169);
    if (CANON) return int'(r) == e;
    return (int'(r) > -QM) && (int'(r) < QM) && (mod_q(longint'(r)) == e);
  endfunction

  function automatic int rand_a();
    return int'($urandom_range(32'd218169343, 32'd0)) - AHALF;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'sd0) $display("FAIL reset_out_data: got %0d want 0", out_data); else n_pass++;
    n_checks++; if (out_tag !== 8'd0) $display("FAIL reset_out_tag: got %0d want 0", out_tag); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else n_pass++;
    #10 rst_n = 1'b1;
  endtask

  task automatic test_single();
    int va [6] = '{0, 65536, 3329, 1, -1, -65536};
    int ve [6] = '{0, 1, 0, 169, -169, -1};
    int cyc;
    if (CANON) begin ve[4] = 3160; ve[5] = 3328; end
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = va[k]; in_tag = 8'(160 + k); out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0; in_data = 32'h5A5A_5A5A; in_tag = 8'hFF;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 12) begin @(posedge clk); #1; cyc++; end
      n_checks++; if (cyc != LAT) $display("FAIL single_latency a=%0d: got %0d want %0d", va[k], cyc, LAT); else n_pass++;
      n_checks++; if (out_data !== 16'(ve[k])) $display("FAIL single_data a=%0d: got %0d want %0d", va[k], out_data, ve[k]); else n_pass++;
      n_checks++; if (out_tag !== 8'(160 + k)) $display("FAIL single_tag a=%0d: got %0d want %0d", va[k], out_tag, 160 + k); else n_pass++;
      @(posedge clk); #1;
      n_checks++; if (out_valid !== 1'b0) $display("FAIL single_dup a=%0d: out_valid got %b want 0", va[k], out_valid); else n_pass++;
    end
  endtask

  task automatic test_extremes();
    int va [2] = '{-AHALF, AHALF - 1};
    int ve [2] = '{0, 3160};
    int cyc;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = va[k]; in_tag = 8'(200 + k); out_ready = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      cyc = 1;
      while (out_valid !== 1'b1 && cyc < 12) begin @(posedge clk); #1; cyc++; end
      n_checks++; if (out_valid !== 1'b1) $display("FAIL extreme_timeout a=%0d: got no output want one", va[k]); else n_pass++;
      n_checks++; if (!result_ok(va[k], out_data)) $display("FAIL extreme_range a=%0d: got %0d want in (-q,q) and == %0d mod q", va[k], out_data, mod_q(longint'(va[k]) * 169)); else n_pass++;
      n_checks++; if (out_data !== 16'(ve[k])) $display("FAIL extreme_data a=%0d: got %0d want %0d", va[k], out_data, ve[k]); else n_pass++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    int a, n_out;
    bit ok_ready, ok_flow;
    sb_a.delete(); sb_tag.delete();
    n_out = 0; ok_ready = 1'b1; ok_flow = 1'b1;
    for (int i = 0; i < 1020; i++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      if (i < 1000) begin in_valid = 1'b1; in_data = rand_a(); in_tag = 8'(i); end
      else in_valid = 1'b0;
      #1;
      if (i < 1000 && in_ready !== 1'b1) ok_ready = 1'b0;
      if (i >= LAT && i < 1000 && out_valid !== 1'b1) ok_flow = 1'b0;
      if (out_valid === 1'b1) begin
        n_out++;
        n_checks++;
        if (sb_a.size() == 0) $display("FAIL b2b_spurious: got tag %0d want no output", out_tag);
        else begin
          a = sb_a.pop_front();
          if (!result_ok(a, out_data) || out_tag !== sb_tag[0])
            $display("FAIL b2b_result a=%0d: got r=%0d tag=%0d want r==%0d mod q tag=%0d", a, out_data, out_tag, mod_q(longint'(a) * 169), sb_tag[0]);
          else n_pass++;
          void'(sb_tag.pop_front());
        end
      end
      if (in_valid && in_ready) begin sb_a.push_back(in_data); sb_tag.push_back(in_tag); end
    end
    n_checks++; if (!ok_ready) $display("FAIL b2b_in_ready: got 0 during stream want 1"); else n_pass++;
    n_checks++; if (!ok_flow) $display("FAIL b2b_throughput: got a gap in out_valid want one per cycle"); else n_pass++;
    n_checks++; if (n_out != 1000) $display("FAIL b2b_count: got %0d want 1000", n_out); else n_pass++;
  endtask

  task automatic test_backpressure();
    int a, n_in, n_out;
    bit prev_stall;
    logic [15:0] prev_d;
    logic [7:0]  prev_t, tag_ctr;
    sb_a.delete(); sb_tag.delete();
    n_in = 0; n_out = 0; prev_stall = 1'b0; prev_d = '0; prev_t = '0; tag_ctr = '0;
    for (int i = 0; i < 840; i++) begin
      @(posedge clk); #1;
      if (i < 800) begin
        in_valid  = ($urandom_range(99, 0) < 60);
        out_ready = ($urandom_range(99, 0) < 30);
      end else begin
        in_valid = 1'b0; out_ready = 1'b1;
      end
      in_data = rand_a(); in_tag = tag_ctr;
      #1;
      if (prev_stall) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== prev_d || out_tag !== prev_t)
          $display("FAIL bp_stable: got v=%b d=%0d t=%0d want v=1 d=%0d t=%0d", out_valid, out_data, out_tag, $signed(prev_d), prev_t);
        else n_pass++;
      end
      n_checks++;
      if (in_ready !== !(out_valid && !out_ready))
        $display("FAIL bp_in_ready: got %b want %b", in_ready, !(out_valid && !out_ready));
      else n_pass++;
      if (out_valid && out_ready) begin
        n_out++;
        n_checks++;
        if (sb_a.size() == 0) $display("FAIL bp_spurious: got tag %0d want no output", out_tag);
        else begin
          a = sb_a.pop_front();
          if (!result_ok(a, out_data) || out_tag !== sb_tag[0])
            $display("FAIL bp_result a=%0d: got r=%0d tag=%0d want r==%0d mod q tag=%0d", a, out_data, out_tag, mod_q(longint'(a) * 169), sb_tag[0]);
          else n_pass++;
          void'(sb_tag.pop_front());
        end
      end
      if (in_valid && in_ready) begin
        sb_a.push_back(in_data); sb_tag.push_back(in_tag);
        tag_ctr++; n_in++;
      end
      prev_stall = out_valid && !out_ready;
      prev_d = out_data; prev_t = out_tag;
    end
    n_checks++; if (n_out != n_in || sb_a.size() != 0) $display("FAIL bp_count: got %0d out want %0d", n_out, n_in); else n_pass++;
  endtask

  task automatic test_full_pipe();
    int fa [5] = '{1000, -2000, 3000, -4000, 5000};
    int idx, a, n_out;
    sb_a.delete(); sb_tag.delete();
    idx = 0; n_out = 0;
    for (int c = 0; c < LAT + 5; c++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = fa[idx]; in_tag = 8'(idx + 1); out_ready = 1'b0;
      #1;
      if (in_ready === 1'b1) begin sb_a.push_back(in_data); sb_tag.push_back(in_tag); idx++; end
    end
    n_checks++; if (idx != LAT) $display("FAIL full_fill: got %0d accepted want %0d", idx, LAT); else n_pass++;
    n_checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL full_stall: got v=%b rdy=%b want v=1 rdy=0", out_valid, in_ready); else n_pass++;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = (c == 0);
      if (c == 0) begin in_data = fa[idx]; in_tag = 8'(idx + 1); end
      #1;
      if (c == 0) begin
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b1) $display("FAIL full_simul: got rdy=%b v=%b want both 1", in_ready, out_valid);
        else n_pass++;
      end
      if (out_valid === 1'b1) begin
        n_out++;
        n_checks++;
        if (sb_a.size() == 0) $display("FAIL full_spurious: got tag %0d want no output", out_tag);
        else begin
          a = sb_a.pop_front();
          if (!result_ok(a, out_data) || out_tag !== sb_tag[0])
            $display("FAIL full_seq a=%0d: got r=%0d tag=%0d want r==%0d mod q tag=%0d", a, out_data, out_tag, mod_q(longint'(a) * 169), sb_tag[0]);
          else n_pass++;
          void'(sb_tag.pop_front());
        end
      end
      if (in_valid && in_ready) begin sb_a.push_back(in_data); sb_tag.push_back(in_tag); end
    end
    n_checks++; if (n_out != LAT + 1) $display("FAIL full_count: got %0d want %0d", n_out, LAT + 1); else n_pass++;
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit stale;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; in_data = 65536 * (k + 5); in_tag = 8'(50 + k); out_ready = 1'b0;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 10) begin @(posedge clk); #1; cyc++; end
    n_checks++; if (out_valid !== 1'b1 || out_data !== 16'sd5) $display("FAIL rstmid_pre: got v=%b d=%0d want v=1 d=5", out_valid, out_data); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++; if (out_valid !== 1'b0) $display("FAIL rstmid_valid: got %b want 0", out_valid); else n_pass++;
    n_checks++; if (out_data !== 16'sd0 || out_tag !== 8'd0) $display("FAIL rstmid_data: got d=%0d t=%0d want 0 0", out_data, out_tag); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready: got %b want 1", in_ready); else n_pass++;
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    stale = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b0;
      #1;
      if (out_valid !== 1'b0) stale = 1'b1;
    end
    n_checks++; if (stale) $display("FAIL rstmid_stale: got out_valid=1 after release want 0"); else n_pass++;
    n_checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_ready_after: got %b want 1", in_ready); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_extremes();
    test_back_to_back();
    test_backpressure();
    test_full_pipe();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout want completion (%0d/%0d so far)", n_pass, n_checks);
    $fatal(1);
  end

endmodule

// File: doc/mont_red.md
Name: mont_red

Overview:
- Streaming, pipelined Montgomery reduction for the Kyber arithmetic datapath (q = 3329, R = 2^16).
- Companion to the Barrett reducer. Barrett is used after additions and subtractions. This block is used after multiplications: it reduces a signed 32-bit product back to a 16-bit coefficient, scaled by R^-1 mod q.
- Sits between the 16x16 coefficient multiplier and the NTT/basemul writeback.
- Uses valid/ready handshakes at both ends, with backpressure and a sideband tag.

Parameters:
- Q, 3329, modulus (signed 16-bit constant).
- QINV, -3327, q^-1 mod 2^16 as signed 16-bit (62209 unsigned).
- TAG_W, 8, width of the sideband tag carried alongside each sample.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  input sample valid
- in_ready  output  1  block can accept a sample this cycle
- in_data  input  32  signed product a; legal range -q*2^15 <= a < q*2^15
- in_tag  input  TAG_W  sideband, returned unchanged with the result
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts the result
- out_data  output  16  signed result r
- out_tag  output  TAG_W  tag of the sample in out_data

Behaviour:
- Reset: rst_n low clears every stage valid bit and every data/tag register immediately (asynchronous). After reset: out_valid=0, out_data=0, out_tag=0, in_ready=1. Reset mid-stream discards all in-flight samples; nothing is emitted after release until new input is accepted.
- Transfer: a transfer occurs on any cycle where valid && ready at a port. in_data/in_tag are sampled only on an input transfer. out_data/out_tag stay stable while out_valid=1 && out_ready=0.
- Pipeline, three registered stages with global advance en = ~s3_valid | out_ready:
  - S1: t = signed low 16 bits of (a * QINV); latch a and tag.
  - S2: p = t * Q (signed 32-bit); forward a and tag.
  - S3: r = (a - p) >>> 16, taking bits [31:16] of the 32-bit difference, which is exact because the low 16 bits are zero.
- Result range: -q < r < q. Relation: r ≡ a * 2^-16 (mod q).
- Handshake rules:
  - in_ready = en (combinational, from registered state and out_ready only).
  - A bubble (stage valid = 0) advances when en = 1.
  - When en = 0 all stages hold.
  - Throughput is one sample per cycle with out_ready held high.
  - Latency is 3 cycles from input transfer to out_valid (4 with the option below).
- Simultaneous input and output transfer in the same cycle with a full pipe: both occur, no loss, no duplication.
- Order is strictly preserved. Tags never separate from their data.
- Out-of-range a: no error flag. Result is the same arithmetic, truncated to 16 bits.

Optional Feature:
- Macro MONT_RED_CANON_EN.
- Defined: adds a fourth stage S4 with r' = (r < 0) ? r + Q : r. out_data is then canonical in [0, q-1] and the latency is 4. The stall logic is extended to the fourth stage; en becomes ~s4_valid | out_ready.
- Undefined: three stages, output in (-q, q), latency 3.

Test Plan:
- Single samples, out_ready=1:
  - a=0 -> 0
  - a=65536 -> 1
  - a=3329 -> 0
  - a=1 -> 169
  - a=-1 -> -169 (3160 with CANON)
  - a=-65536 -> -1 (3328 with CANON)
  - Each arrives exactly 3 cycles after input (4 with CANON), with the tag echoed.
- Back-to-back stream: 1000 random legal a, in_valid=1, out_ready=1 -> one output per cycle; each r ≡ a*169 mod 3329 and -3329 < r < 3329; tags arrive in order.
- Backpressure: random out_ready duty 30% with random in_valid -> no drops or duplicates; out_data/out_tag stable while stalled; in_ready=0 exactly when S3 is valid and out_ready=0.
- Full-pipe simultaneous in/out: fill 3 samples, hold out_ready=0 for 5 cycles, then out_ready=1 with in_valid=1 -> output and input transfer in the same cycle; sequence is intact.
- Async reset mid-stream: assert rst_n=0 between clock edges with 3 samples in flight -> out_valid=0 and out_data=0 immediately; after release no stale output; in_ready=1.
- Range extremes: a = -3329*32768 and a = 3329*32768-1 -> results within (-3329, 3329) and congruent to a*169 mod 3329.
